vga_axil_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register file. It sits behind the VGA AXI-Lite bus and exposes NUM_REGS software registers to the VGA core.
- Next-generation features:
  - full wstrb byte-lane support;
  - independently buffered AW and W channels;
  - per-register read-only (hardware-driven) registers;
  - DECERR/SLVERR responses;
  - per-register write pulses.

---
 rtl/vga_axil_regfile_if.sv | 35 +++
 rtl/vga_axil_regfile.sv | 177 +++++++++++++++++
 tb/tb_vga_axil_regfile.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_axil_regfile_if.sv
// AXI4-Lite bus bundle between the VGA bus master and the register file.
interface vga_axil_regfile_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite slave register file: buffered AW/W, byte strobes, read-only
// hardware slots, DECERR/SLVERR responses and per-register write pulses.
module vga_axil_regfile #(
    parameter int unsigned                  ADDR_W    = 32,
    parameter int unsigned                  DATA_W    = 32,
    parameter int unsigned                  NUM_REGS  = 8,
    parameter logic [NUM_REGS-1:0]          RO_MASK   = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         arst_n,
    vga_axil_regfile_if.slave            bus,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_i,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned AL     = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic                out_of_reset;
    logic                aw_full;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic                w_full;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic                rvalid_q;
    logic [1:0]          rresp_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_REGS-1:0] wr_pulse_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   hw_arr [NUM_REGS];

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                b_hs;
    logic                r_hs;
    logic                commit;
    logic [1:0]          wr_resp;
    logic [1:0]          rd_resp;
    logic [IDX_W-1:0]    widx;
    logic [IDX_W-1:0]    ridx;

    // Response decode; low address bits are dropped so unaligned addresses alias.
    function automatic logic [1:0] decode(input logic [ADDR_W-1:0] addr, input logic is_wr);
        logic [ADDR_W-1:0] idx_full;
        idx_full = addr >> AL;
        if (idx_full >= ADDR_W'(NUM_REGS)) begin
            return RESP_DECERR;
        end else if (is_wr && RO_MASK[IDX_W'(idx_full)]) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

    assign bus.awready = out_of_reset && !aw_full;
    assign bus.wready  = out_of_reset && !w_full;
    assign bus.arready = out_of_reset && !rvalid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
    assign wr_pulse_o  = wr_pulse_q;

    assign aw_hs  = bus.awvalid && bus.awready;
    assign w_hs   = bus.wvalid  && bus.wready;
    assign ar_hs  = bus.arvalid && bus.arready;
    assign b_hs   = bvalid_q    && bus.bready;
    assign r_hs   = rvalid_q    && bus.rready;
    assign commit = aw_full && w_full && (!bvalid_q || bus.bready);

    assign widx    = IDX_W'(aw_addr_q >> AL);
    assign ridx    = IDX_W'(bus.araddr >> AL);
    assign wr_resp = decode(aw_addr_q, 1'b1);
    assign rd_resp = decode(bus.araddr, 1'b0);

    // Flattened views; read-only slots expose 0 on regs_o.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        assign hw_arr[i]                     = hw_i[i*DATA_W +: DATA_W];
        assign regs_o[i*DATA_W +: DATA_W]    = RO_MASK[i] ? '0 : regs_q[i];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    // AW and W single-entry buffers, drained together by a commit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
            w_full    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= bus.awaddr;
            end
            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
        end
    end

    // Commit: register update, write pulse and B response.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            wr_pulse_q <= '0;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
                if (wr_resp == RESP_OKAY) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            regs_q[widx][b*8 +: 8] <= w_data_q[b*8 +: 8];
                        end
                    end
                    if (w_strb_q != '0) begin
                        wr_pulse_q <= NUM_REGS'(1) << widx;
                    end
                end
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
                bresp_q  <= RESP_OKAY;
            end
        end
    end

    // Single-outstanding read; values are sampled at the AR handshake.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_resp;
                if (rd_resp == RESP_DECERR) begin
                    rdata_q <= '0;
                end else if (RO_MASK[ridx]) begin
                    rdata_q <= hw_arr[ridx];
                end else begin
                    rdata_q <= regs_q[ridx];
                end
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed bench for vga_axil_regfile: vector table plus ordering, backpressure,
// collision and mid-operation reset sequences.
module tb_vga_axil_regfile;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 4;
    localparam logic [3:0]   RO_MASK   = 4'b1000;
    localparam logic [127:0] RESET_VAL = {32'h0000_0000, 32'h3333_3333, 32'h2222_2222, 32'h1122_3344};
    localparam logic [127:0] HW_VAL    = {32'hCAFE_F00D, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};

    logic         clk = 1'b0;
    logic         arst_n;
    logic [127:0] regs_o;
    logic [127:0] hw_i;
    logic [3:0]   wr_pulse_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_axil_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_axil_regfile #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .bus       (bus),
        .regs_o    (regs_o),
        .hw_i      (hw_i),
        .wr_pulse_o(wr_pulse_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        logic [3:0]  pulse;
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input int n, input vec_t v);
        bus.awaddr  = v.addr;
        bus.wdata   = v.wdata;
        bus.wstrb   = v.wstrb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        check($sformatf("v%0d_awready", n), 128'(bus.awready), 128'(1));
        check($sformatf("v%0d_wready", n), 128'(bus.wready), 128'(1));
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check($sformatf("v%0d_bvalid_e0", n), 128'(bus.bvalid), 128'(0));
        tick();
        check($sformatf("v%0d_bvalid_e1", n), 128'(bus.bvalid), 128'(1));
        check($sformatf("v%0d_bresp", n), 128'(bus.bresp), 128'(v.bresp));
        check($sformatf("v%0d_pulse", n), 128'(wr_pulse_o), 128'(v.pulse));
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check($sformatf("v%0d_bvalid_clr", n), 128'(bus.bvalid), 128'(0));
        check($sformatf("v%0d_pulse_clr", n), 128'(wr_pulse_o), 128'(0));
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        check({name, "_arready"}, 128'(bus.arready), 128'(1));
        tick();
        bus.arvalid = 1'b0;
        check({name, "_rvalid"}, 128'(bus.rvalid), 128'(1));
        check({name, "_rdata"}, 128'(bus.rdata), 128'(exp_data));
        check({name, "_rresp"}, 128'(bus.rresp), 128'(exp_resp));
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check({name, "_rvalid_clr"}, 128'(bus.rvalid), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 4'b0010, 32'h04, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{32'h00, 32'hAABB_CCDD, 4'h5, 2'b00, 4'b0001, 32'h00, 32'h11BB_33DD, 2'b00};
        vecs[2] = '{32'h00, 32'hFFFF_FFFF, 4'h0, 2'b00, 4'b0000, 32'h00, 32'h11BB_33DD, 2'b00};
        vecs[3] = '{32'h10, 32'h1234_5678, 4'hF, 2'b11, 4'b0000, 32'h10, 32'h0000_0000, 2'b11};
        vecs[4] = '{32'h0C, 32'h1234_5678, 4'hF, 2'b10, 4'b0000, 32'h0C, 32'hCAFE_F00D, 2'b00};
        vecs[5] = '{32'h09, 32'h0000_AB00, 4'h2, 2'b00, 4'b0100, 32'h0A, 32'h3333_AB33, 2'b00};
        vecs[6] = '{32'h07, 32'h5A00_0000, 4'h8, 2'b00, 4'b0010, 32'h05, 32'h5AAD_BEEF, 2'b00};

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        hw_i   = HW_VAL;
        arst_n = 1'b0;
        #12;
        check("rst_awready", 128'(bus.awready), 128'(0));
        check("rst_bvalid", 128'(bus.bvalid), 128'(0));
        check("rst_rvalid", 128'(bus.rvalid), 128'(0));
        check("rst_rdata", 128'(bus.rdata), 128'(0));
        check("rst_pulse", 128'(wr_pulse_o), 128'(0));
        check("rst_regs", regs_o, RESET_VAL);
        @(posedge clk);
        #1 arst_n = 1'b1;
        check("rel_awready_low", 128'(bus.awready), 128'(0));
        check("rel_arready_low", 128'(bus.arready), 128'(0));
        tick();
        check("rel_awready", 128'(bus.awready), 128'(1));
        check("rel_wready", 128'(bus.wready), 128'(1));
        check("rel_arready", 128'(bus.arready), 128'(1));

        for (int i = 0; i < 7; i++) begin
            write_vec(i, vecs[i]);
            read_chk($sformatf("v%0d_rd", i), vecs[i].raddr, vecs[i].rdata, vecs[i].rresp);
        end

        // W three cycles ahead of AW
        bus.wdata = 32'h0102_0304; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wfirst_wready_%0d", i), 128'(bus.wready), 128'(0));
            check($sformatf("wfirst_bvalid_%0d", i), 128'(bus.bvalid), 128'(0));
            tick();
        end
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        check("wfirst_awready", 128'(bus.awready), 128'(1));
        tick();
        bus.awvalid = 1'b0;
        check("wfirst_wready_hold", 128'(bus.wready), 128'(0));
        check("wfirst_bvalid_e0", 128'(bus.bvalid), 128'(0));
        tick();
        check("wfirst_bvalid", 128'(bus.bvalid), 128'(1));
        check("wfirst_bresp", 128'(bus.bresp), 128'(0));
        check("wfirst_pulse", 128'(wr_pulse_o), 128'(4'b0100));
        check("wfirst_reg2", 128'(regs_o[95:64]), 128'(32'h0102_0304));
        check("wfirst_wready_free", 128'(bus.wready), 128'(1));

        // Backpressure: second write buffers but waits for the B handshake
        bus.awaddr = 32'h10; bus.wdata = 32'h0000_0077; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_bvalid_%0d", i), 128'(bus.bvalid), 128'(1));
            check($sformatf("bp_bresp_%0d", i), 128'(bus.bresp), 128'(0));
            check($sformatf("bp_awready_%0d", i), 128'(bus.awready), 128'(0));
            tick();
        end
        bus.bready = 1'b1;
        tick();
        check("bp_bvalid_next", 128'(bus.bvalid), 128'(1));
        check("bp_bresp_next", 128'(bus.bresp), 128'(2'b11));
        check("bp_awready_free", 128'(bus.awready), 128'(1));
        tick();
        bus.bready = 1'b0;
        check("bp_bvalid_clr", 128'(bus.bvalid), 128'(0));
        check("bp_regs", regs_o, {32'h0, 32'h0102_0304, 32'h5AAD_BEEF, 32'h11BB_33DD});

        // Read and commit to the same register on one edge
        bus.awaddr = 32'h08; bus.wdata = 32'h9999_9999; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h08; bus.arvalid = 1'b1;
        check("col_arready", 128'(bus.arready), 128'(1));
        tick();
        bus.arvalid = 1'b0;
        check("col_rvalid", 128'(bus.rvalid), 128'(1));
        check("col_rdata_old", 128'(bus.rdata), 128'(32'h0102_0304));
        check("col_bvalid", 128'(bus.bvalid), 128'(1));
        check("col_reg2", 128'(regs_o[95:64]), 128'(32'h9999_9999));
        bus.rready = 1'b1; bus.bready = 1'b1;
        tick();
        bus.rready = 1'b0; bus.bready = 1'b0;
        read_chk("col_rd_new", 32'h08, 32'h9999_9999, 2'b00);

        // Reset with B, R pending and AW buffered
        bus.awaddr = 32'h00; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick();
        bus.araddr = 32'h04; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("mr_pre_bvalid", 128'(bus.bvalid), 128'(1));
        check("mr_pre_rvalid", 128'(bus.rvalid), 128'(1));
        check("mr_pre_awready", 128'(bus.awready), 128'(0));
        #2 arst_n = 1'b0;
        #1;
        check("mr_bvalid", 128'(bus.bvalid), 128'(0));
        check("mr_rvalid", 128'(bus.rvalid), 128'(0));
        check("mr_awready", 128'(bus.awready), 128'(0));
        check("mr_wready", 128'(bus.wready), 128'(0));
        check("mr_arready", 128'(bus.arready), 128'(0));
        check("mr_regs", regs_o, RESET_VAL);
        @(posedge clk);
        #1 arst_n = 1'b1;
        check("mr_rel_awready_low", 128'(bus.awready), 128'(0));
        tick();
        check("mr_rel_awready", 128'(bus.awready), 128'(1));
        check("mr_rel_wready", 128'(bus.wready), 128'(1));
        check("mr_rel_arready", 128'(bus.arready), 128'(1));
        bus.wdata = 32'hA5A5_A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mr_no_commit_%0d", i), 128'(bus.bvalid), 128'(0));
            tick();
        end
        check("mr_regs_idle", regs_o, RESET_VAL);
        bus.awaddr = 32'h04; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        tick();
        check("mr_new_bvalid", 128'(bus.bvalid), 128'(1));
        check("mr_new_bresp", 128'(bus.bresp), 128'(0));
        check("mr_new_regs", regs_o, {32'h0, 32'h3333_3333, 32'hA5A5_A5A5, 32'h1122_3344});
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
